// File: rtl/reg_dest_scoreboard.sv
// Pending-write scoreboard for the 32 GPRs: counts in-flight writes per register and flags
// rs/rt hazards for decode. Optional same-cycle writeback bypass under `WB_BYPASS_EN.
module reg_dest_scoreboard #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [NREG-1:0]   busy_vec,
  output logic              underflow_err
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             underflow_q, underflow_d;

  logic inc, dec, wb_miss;
  logic rs_wb_clear, rt_wb_clear;

  // A saturated counter back-pressures issue so the counter can never wrap.
  always_comb begin
    issue_ready = (issue_dest == '0) || (cnt_q[issue_dest] != CntMax);
    inc         = issue_valid && issue_ready && (issue_dest != '0);
    dec         = wb_valid && (wb_dest != '0) && (cnt_q[wb_dest] != '0);
    wb_miss     = wb_valid && (wb_dest != '0) && (cnt_q[wb_dest] == '0);
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      cnt_d[i] = cnt_q[i];
      if (i != 0) begin
        unique case ({inc && (issue_dest == ADDR_W'(i)), dec && (wb_dest == ADDR_W'(i))})
          2'b10:   cnt_d[i] = cnt_q[i] + CntOne;
          2'b01:   cnt_d[i] = cnt_q[i] - CntOne;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end else begin
        cnt_d[i] = '0;
      end
    end
    underflow_d = underflow_q || wb_miss;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= '0;
      end
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      busy_vec[i] = (i != 0) && (cnt_q[i] != '0);
    end
  end

`ifdef WB_BYPASS_EN
  // The last outstanding writer is in WB now; the RF write lands before the read.
  always_comb begin
    rs_wb_clear = wb_valid && (wb_dest == rs_addr) && (cnt_q[rs_addr] == CntOne);
    rt_wb_clear = wb_valid && (wb_dest == rt_addr) && (cnt_q[rt_addr] == CntOne);
  end
`else
  always_comb begin
    rs_wb_clear = 1'b0;
    rt_wb_clear = 1'b0;
  end
`endif

  always_comb begin
    rs_busy       = busy_vec[rs_addr] && !rs_wb_clear;
    rt_busy       = busy_vec[rt_addr] && !rt_wb_clear;
    underflow_err = underflow_q;
  end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Scoreboard bench for reg_dest_scoreboard: the driver queues hand-computed expectations per
// cycle and a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_dest_scoreboard;

`ifdef WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic [31:0] busy_vec;
  logic        underflow_err;

  reg_dest_scoreboard #(
    .ADDR_W(5),
    .NREG  (32),
    .CNT_W (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_dest   (issue_dest),
    .issue_ready  (issue_ready),
    .wb_valid     (wb_valid),
    .wb_dest      (wb_dest),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_busy      (rs_busy),
    .rt_busy      (rt_busy),
    .busy_vec     (busy_vec),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ready;
    bit          rs;
    bit          rt;
    logic [31:0] vec;
    bit          uf;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %h want %h", nm, fld, got, want);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "issue_ready", 32'(issue_ready), 32'(e.ready));
        cmp(e.name, "rs_busy", 32'(rs_busy), 32'(e.rs));
        cmp(e.name, "rt_busy", 32'(rt_busy), 32'(e.rt));
        cmp(e.name, "busy_vec", busy_vec, e.vec);
        cmp(e.name, "underflow_err", 32'(underflow_err), 32'(e.uf));
      end
    end
  end

  task automatic step(input bit r, input bit iv, input logic [4:0] id, input bit wv,
                      input logic [4:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                      input bit e_ready, input bit e_rs, input bit e_rt,
                      input logic [31:0] e_vec, input bit e_uf, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    issue_valid = iv;
    issue_dest  = id;
    wb_valid    = wv;
    wb_dest     = wd;
    rs_addr     = rs;
    rt_addr     = rt;
    e.ready = e_ready;
    e.rs    = e_rs;
    e.rt    = e_rt;
    e.vec   = e_vec;
    e.uf    = e_uf;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  localparam logic [31:0] B3  = 32'h1 << 3;
  localparam logic [31:0] B5  = 32'h1 << 5;
  localparam logic [31:0] B8  = 32'h1 << 8;
  localparam logic [31:0] B9  = 32'h1 << 9;
  localparam logic [31:0] B12 = 32'h1 << 12;
  localparam logic [31:0] B31 = 32'h1 << 31;

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_dest = '0; wb_valid = 1'b0; wb_dest = '0;
    rs_addr = '0; rt_addr = '0;
    @(posedge clk);
    //    rst iv id   wv wd  rs  rt   rdy rs   rt   vec   uf
    step(0, 0, 0,  0, 0,  0,  0,  1,  0,   0,   0,    0, "reset");
    step(0, 1, 8,  0, 0,  8,  0,  1,  0,   0,   0,    0, "issue8_own");
    step(0, 0, 0,  0, 0,  8,  8,  1,  1,   1,   B8,   0, "r8_busy");
    step(0, 0, 0,  1, 8,  8,  0,  1,  !Byp, 0,  B8,   0, "wb8_cycle");
    step(0, 0, 0,  0, 0,  8,  0,  1,  0,   0,   0,    0, "r8_clear");
    step(0, 1, 5,  0, 0,  0,  0,  1,  0,   0,   0,    0, "issue5_a");
    step(0, 1, 5,  0, 0,  0,  0,  1,  0,   0,   B5,   0, "issue5_b");
    step(0, 1, 5,  0, 0,  0,  0,  1,  0,   0,   B5,   0, "issue5_c");
    step(0, 1, 5,  0, 0,  5,  0,  0,  1,   0,   B5,   0, "issue5_drop");
    step(0, 0, 5,  1, 5,  5,  0,  0,  1,   0,   B5,   0, "wb5_a");
    step(0, 0, 5,  1, 5,  5,  0,  1,  1,   0,   B5,   0, "wb5_b");
    step(0, 0, 0,  1, 5,  5,  0,  1,  !Byp, 0,  B5,   0, "wb5_c");
    step(0, 0, 5,  0, 0,  5,  0,  1,  0,   0,   0,    0, "r5_clear");
    step(0, 1, 9,  0, 0,  0,  0,  1,  0,   0,   0,    0, "issue9");
    step(0, 1, 9,  1, 9,  9,  0,  1,  !Byp, 0,  B9,   0, "inc_dec9");
    step(0, 1, 3,  1, 9,  9,  3,  1,  !Byp, 0,  B9,   0, "issue3_wb9");
    step(0, 0, 0,  0, 0,  9,  3,  1,  0,   1,   B3,   0, "r3_r9");
    step(0, 1, 0,  1, 0,  0,  3,  1,  0,   1,   B3,   0, "reg0_noop");
    step(0, 0, 0,  1, 3,  0,  3,  1,  0,   !Byp, B3,  0, "wb3");
    step(0, 0, 0,  0, 0,  0,  0,  1,  0,   0,   0,    0, "empty");
    step(0, 0, 0,  1, 12, 12, 0,  1,  0,   0,   0,    0, "wb12_under");
    step(0, 0, 0,  0, 0,  0,  0,  1,  0,   0,   0,    1, "uf_set");
    step(0, 1, 12, 0, 0,  0,  0,  1,  0,   0,   0,    1, "issue12");
    step(0, 0, 0,  0, 0,  12, 0,  1,  1,   0,   B12,  1, "uf_sticky");
    step(1, 0, 0,  0, 0,  12, 0,  1,  1,   0,   B12,  1, "rst_cycle");
    step(0, 0, 0,  0, 0,  12, 0,  1,  0,   0,   0,    0, "after_rst");
    step(0, 1, 31, 0, 0,  0,  31, 1,  0,   0,   0,    0, "issue31");
    step(0, 0, 0,  0, 0,  1,  31, 1,  0,   1,   B31,  0, "r31_busy");
    step(0, 0, 0,  1, 31, 0,  31, 1,  0,   !Byp, B31, 0, "wb31");
    step(0, 0, 0,  0, 0,  0,  31, 1,  0,   0,   0,    0, "r31_clear");
    step(0, 0, 0,  0, 0,  0,  0,  1,  0,   0,   0,    0, "idle");
    // Bounded drain of the expectation queue.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
